// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM encoding,
// counter widths, register-file constants and default latencies.
package pipe_ctrl_pkg;

    localparam int unsigned REG_ADDR_W            = 5;
    localparam int unsigned MULDIV_CNT_W          = 8;
    localparam int unsigned WAIT_CNT_W            = 16;
    localparam int unsigned DEFAULT_MULDIV_CYCLES = 32;
    localparam int unsigned DEFAULT_MEM_TIMEOUT   = 64;

    // $zero is never a real producer, so it never creates a dependency
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MULDIV   = 2'd2
    } state_e;

    // Load in EX writes a register the ID instruction is about to read
    function automatic logic load_use_hit(
        input logic                  ex_memread,
        input logic [REG_ADDR_W-1:0] ex_rt,
        input logic [REG_ADDR_W-1:0] id_rs,
        input logic [REG_ADDR_W-1:0] id_rt,
        input logic                  id_uses_rt
    );
        return ex_memread && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/muldiv_tracker.sv
// Mult/div occupancy tracker: start acceptance, latency countdown and busy
// flag. Only built when HAZARD_MULDIV_EN is defined.
`ifdef HAZARD_MULDIV_EN
module muldiv_tracker
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = DEFAULT_MULDIV_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic mem_stall_i,
    input  logic branch_i,
    input  logic in_muldiv_i,
    output logic start_acc_c_o,
    output logic busy_c_o,
    output logic cnt_nz_c_o
);

    localparam logic [MULDIV_CNT_W-1:0] CNT_LOAD = MULDIV_CNT_W'(MULDIV_CYCLES - 1);

    logic [MULDIV_CNT_W-1:0] cnt_q, cnt_d;

    // A frozen EX instruction is re-presented later; a start paired with a
    // taken branch is a protocol error and the branch wins.
    assign start_acc_c_o = start_i && !mem_stall_i && !branch_i;

    // Reload on an accepted start, otherwise count down to zero (even while frozen)
    always_comb begin
        cnt_d = cnt_q;
        if (start_acc_c_o) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - MULDIV_CNT_W'(1);
        end
    end

    // Countdown register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The last busy cycle is the one where the count sits at zero in MULDIV
    assign cnt_nz_c_o = (cnt_q != '0);
    assign busy_c_o   = cnt_nz_c_o || in_muldiv_i;

endmodule
`endif

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline. Resolves load-use,
// mult/div HI/LO occupancy and data-memory wait states, and squashes the
// wrong-path fetch on a taken branch. Control outputs are Mealy.
// Optional feature macro: HAZARD_MULDIV_EN (mult/div tracking and HI/LO rule).
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = DEFAULT_MULDIV_CYCLES,
    parameter int unsigned MEM_TIMEOUT   = DEFAULT_MEM_TIMEOUT
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [REG_ADDR_W-1:0] IF_ID_Reg_RS,
    input  logic [REG_ADDR_W-1:0] IF_ID_Reg_RT,
    input  logic                  ID_UsesRT,
    input  logic                  ID_UsesHiLo,
    input  logic [REG_ADDR_W-1:0] ID_EX_Reg_RT,
    input  logic                  ID_EX_MemRead,
    input  logic                  EX_BranchTaken,
    input  logic                  EX_MulDivStart,
    input  logic                  EX_MEM_MemAccess,
    input  logic                  MEM_Ready,
    output logic                  PC_Write,
    output logic                  IF_ID_Write,
    output logic                  IF_ID_Flush,
    output logic                  ID_EX_Bubble,
    output logic                  Pipe_Freeze,
    output logic                  MulDiv_Busy,
    output logic                  Mem_Timeout,
    output logic [1:0]            State
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX = WAIT_CNT_W'(MEM_TIMEOUT - 1);

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_q, wait_d;
    logic                    timeout_q, timeout_d;
    logic                    lu_stall_q, lu_stall_d;

    logic                    mem_stall;
    logic                    load_use;
    logic                    muldiv_start_acc;
    logic                    muldiv_busy;
    logic                    muldiv_cnt_nz;
    logic                    hilo_hazard;

    // Memory has not finished the access in MEM: everything behind it must hold
    assign mem_stall = EX_MEM_MemAccess && !MEM_Ready;

    // A load-use stall lasts one cycle; the bubble then moves the load to MEM
    assign load_use = !lu_stall_q &&
                      load_use_hit(ID_EX_MemRead, ID_EX_Reg_RT, IF_ID_Reg_RS,
                                   IF_ID_Reg_RT, ID_UsesRT);

`ifdef HAZARD_MULDIV_EN
    muldiv_tracker #(
        .MULDIV_CYCLES (MULDIV_CYCLES)
    ) u_muldiv_tracker (
        .clk_i         (CLK),
        .rst_i         (Reset),
        .start_i       (EX_MulDivStart),
        .mem_stall_i   (mem_stall),
        .branch_i      (EX_BranchTaken),
        .in_muldiv_i   (state_q == ST_MULDIV),
        .start_acc_c_o (muldiv_start_acc),
        .busy_c_o      (muldiv_busy),
        .cnt_nz_c_o    (muldiv_cnt_nz)
    );

    assign hilo_hazard = muldiv_busy && ID_UsesHiLo;
`else
    logic unused_muldiv;

    // Mult/div tracking absent: its inputs are deliberately ignored
    assign unused_muldiv    = ^{EX_MulDivStart, ID_UsesHiLo, MULDIV_CNT_W'(MULDIV_CYCLES)};
    assign muldiv_start_acc = 1'b0;
    assign muldiv_busy      = 1'b0;
    assign muldiv_cnt_nz    = 1'b0;
    assign hilo_hazard      = 1'b0;
`endif

    // Next state, wait counter, sticky timeout and prioritised control outputs
    always_comb begin
        state_d      = state_q;
        wait_d       = '0;
        timeout_d    = timeout_q;
        lu_stall_d   = 1'b0;
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        Pipe_Freeze  = 1'b0;

        if (mem_stall) begin
            state_d = ST_MEM_WAIT;
        end else if (muldiv_start_acc) begin
            state_d = ST_MULDIV;
        end else begin
            case (state_q)
                ST_MEM_WAIT: state_d = muldiv_cnt_nz ? ST_MULDIV : ST_RUN;
                ST_MULDIV:   state_d = muldiv_cnt_nz ? ST_MULDIV : ST_RUN;
                default:     state_d = ST_RUN;
            endcase
        end

        // Count wait cycles only while the wait persists; saturate at the limit
        if ((state_q == ST_MEM_WAIT) && (state_d == ST_MEM_WAIT)) begin
            wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_CNT_W'(1);
            if (wait_d == WAIT_MAX) begin
                timeout_d = 1'b1;
            end
        end

        if (!Reset) begin
            if (mem_stall) begin
                Pipe_Freeze = 1'b1;
                PC_Write    = 1'b0;
                IF_ID_Write = 1'b0;
            end else if (EX_BranchTaken) begin
                // ID holds a wrong-path instruction, so its hazards are moot
                IF_ID_Flush  = 1'b1;
                ID_EX_Bubble = 1'b1;
            end else if (hilo_hazard) begin
                PC_Write     = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Bubble = 1'b1;
            end else if (load_use) begin
                PC_Write     = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Bubble = 1'b1;
                lu_stall_d   = 1'b1;
            end
        end
    end

    // State, wait counter, timeout flag and load-use history
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= ST_RUN;
            wait_q     <= '0;
            timeout_q  <= 1'b0;
            lu_stall_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            timeout_q  <= timeout_d;
            lu_stall_q <= lu_stall_d;
        end
    end

    // Reset forces the status outputs to their idle values immediately
    assign State       = Reset ? ST_RUN : state_q;
    assign Mem_Timeout = timeout_q && !Reset;
    assign MulDiv_Busy = muldiv_busy && !Reset;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (MULDIV_CYCLES=4, MEM_TIMEOUT=8).
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       uses_hilo;
        logic [4:0] ex_rt;
        logic       ex_memread;
        logic       br;
        logic       mds;
        logic       memacc;
        logic       ready;
    } in_t;

    typedef struct packed {
        logic       pcw;
        logic       ifw;
        logic       flush;
        logic       bubble;
        logic       freeze;
        logic       busy;
        logic       tmo;
        logic [1:0] st;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [4:0] IF_ID_Reg_RS, IF_ID_Reg_RT, ID_EX_Reg_RT;
    logic       ID_UsesRT, ID_UsesHiLo, ID_EX_MemRead, EX_BranchTaken;
    logic       EX_MulDivStart, EX_MEM_MemAccess, MEM_Ready;
    logic       PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze;
    logic       MulDiv_Busy, Mem_Timeout;
    logic [1:0] State;

    int checks = 0;
    int errors = 0;

    exp_t  sb_exp[$];
    string sb_name[$];

    pipeline_hazard_ctrl #(
        .MULDIV_CYCLES (4),
        .MEM_TIMEOUT   (8)
    ) dut (
        .CLK              (CLK),
        .Reset            (Reset),
        .IF_ID_Reg_RS     (IF_ID_Reg_RS),
        .IF_ID_Reg_RT     (IF_ID_Reg_RT),
        .ID_UsesRT        (ID_UsesRT),
        .ID_UsesHiLo      (ID_UsesHiLo),
        .ID_EX_Reg_RT     (ID_EX_Reg_RT),
        .ID_EX_MemRead    (ID_EX_MemRead),
        .EX_BranchTaken   (EX_BranchTaken),
        .EX_MulDivStart   (EX_MulDivStart),
        .EX_MEM_MemAccess (EX_MEM_MemAccess),
        .MEM_Ready        (MEM_Ready),
        .PC_Write         (PC_Write),
        .IF_ID_Write      (IF_ID_Write),
        .IF_ID_Flush      (IF_ID_Flush),
        .ID_EX_Bubble     (ID_EX_Bubble),
        .Pipe_Freeze      (Pipe_Freeze),
        .MulDiv_Busy      (MulDiv_Busy),
        .Mem_Timeout      (Mem_Timeout),
        .State            (State)
    );

    always #5 CLK = ~CLK;

    function automatic in_t mk_in(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic urt, input logic uhl, input logic [4:0] exrt,
                                  input logic mrd, input logic br, input logic mds,
                                  input logic macc, input logic rdy);
        in_t v;
        v.rst = rst; v.rs = rs; v.rt = rt; v.uses_rt = urt; v.uses_hilo = uhl;
        v.ex_rt = exrt; v.ex_memread = mrd; v.br = br; v.mds = mds;
        v.memacc = macc; v.ready = rdy;
        return v;
    endfunction

    function automatic exp_t ex(input logic pcw, input logic ifw, input logic flush,
                                input logic bub, input logic frz, input logic busy,
                                input logic tmo, input logic [1:0] st);
        exp_t e;
        e.pcw = pcw; e.ifw = ifw; e.flush = flush; e.bubble = bub;
        e.freeze = frz; e.busy = busy; e.tmo = tmo; e.st = st;
        return e;
    endfunction

    task automatic drive(input in_t v);
        Reset            = v.rst;
        IF_ID_Reg_RS     = v.rs;
        IF_ID_Reg_RT     = v.rt;
        ID_UsesRT        = v.uses_rt;
        ID_UsesHiLo      = v.uses_hilo;
        ID_EX_Reg_RT     = v.ex_rt;
        ID_EX_MemRead    = v.ex_memread;
        EX_BranchTaken   = v.br;
        EX_MulDivStart   = v.mds;
        EX_MEM_MemAccess = v.memacc;
        MEM_Ready        = v.ready;
    endtask

    task automatic check_out();
        exp_t       e, act;
        string      nm;
        logic [8:0] av, ev;
        e   = sb_exp.pop_front();
        nm  = sb_name.pop_front();
        act = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze,
               MulDiv_Busy, Mem_Timeout, State};
        av  = act;
        ev  = e;
        checks++;
        if (av !== ev) begin
            errors++;
            $display("FAIL %s: {pcw,ifw,flush,bub,frz,busy,tmo,st} got %b want %b", nm, av, ev);
        end
    endtask

    // Drive one cycle's inputs after the edge, compare outputs mid-cycle
    task automatic run_cycle(input in_t v, input exp_t e, input string nm);
        @(posedge CLK);
        #1;
        drive(v);
        sb_exp.push_back(e);
        sb_name.push_back(nm);
        @(negedge CLK);
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_t   idle, rst_v, stall, lu, hilo, mds_v, v;
        exp_t  E_RUN, E_LU, E_BR;
        vec_t  tbl[12];
        string tbl_nm[12];

        idle  = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        rst_v = mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        stall = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        lu    = mk_in(0, 8, 3, 0, 0, 8, 1, 0, 0, 0, 1);
        hilo  = mk_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        mds_v = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        E_RUN = ex(1, 1, 0, 0, 0, 0, 0, 2'd0);
        E_LU  = ex(0, 0, 0, 1, 0, 0, 0, 2'd0);
        E_BR  = ex(1, 1, 1, 1, 0, 0, 0, 2'd0);

        drive(rst_v);

        tbl_nm[0]  = "reset_overrides";  tbl[0].i  = mk_in(1, 8, 0, 0, 1, 8, 1, 1, 1, 1, 0); tbl[0].e  = E_RUN;
        tbl_nm[1]  = "idle";             tbl[1].i  = idle;                                  tbl[1].e  = E_RUN;
        tbl_nm[2]  = "lu_rs";            tbl[2].i  = lu;                                    tbl[2].e  = E_LU;
        tbl_nm[3]  = "lu_zero_reg";      tbl[3].i  = mk_in(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1); tbl[3].e  = E_RUN;
        tbl_nm[4]  = "lu_rt_used";       tbl[4].i  = mk_in(0, 4, 9, 1, 0, 9, 1, 0, 0, 0, 1); tbl[4].e  = E_LU;
        tbl_nm[5]  = "lu_rt_unused";     tbl[5].i  = mk_in(0, 4, 9, 0, 0, 9, 1, 0, 0, 0, 1); tbl[5].e  = E_RUN;
        tbl_nm[6]  = "no_memread";       tbl[6].i  = mk_in(0, 8, 8, 1, 0, 8, 0, 0, 0, 0, 1); tbl[6].e  = E_RUN;
        tbl_nm[7]  = "branch";           tbl[7].i  = mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1); tbl[7].e  = E_BR;
        tbl_nm[8]  = "branch_over_lu";   tbl[8].i  = mk_in(0, 8, 0, 0, 0, 8, 1, 1, 0, 0, 1); tbl[8].e  = E_BR;
        tbl_nm[9]  = "branch_with_mds";  tbl[9].i  = mk_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1); tbl[9].e  = E_BR;
        tbl_nm[10] = "mem_ready_now";    tbl[10].i = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); tbl[10].e = E_RUN;
        tbl_nm[11] = "hilo_not_busy";    tbl[11].i = hilo;                                  tbl[11].e = E_RUN;

        run_cycle(rst_v, E_RUN, "reset0");
        run_cycle(rst_v, E_RUN, "reset1");

        // Each vector followed by an idle cycle that must show no residue
        for (int k = 0; k < 12; k++) begin
            run_cycle(tbl[k].i, tbl[k].e, tbl_nm[k]);
            run_cycle(idle, E_RUN, {tbl_nm[k], "_after"});
        end

        // Load-use held for two cycles stalls only the first
        run_cycle(lu, E_LU, "lu_hold_c1");
        run_cycle(lu, E_RUN, "lu_hold_c2");
        run_cycle(idle, E_RUN, "lu_hold_after");

        // Three-cycle memory stall with a branch during the freeze
        run_cycle(stall, ex(0, 0, 0, 0, 1, 0, 0, 2'd0), "mstall_c1");
        v = stall; v.br = 1'b1;
        run_cycle(v, ex(0, 0, 0, 0, 1, 0, 0, 2'd1), "mstall_c2_branch");
        run_cycle(stall, ex(0, 0, 0, 0, 1, 0, 0, 2'd1), "mstall_c3");
        v = stall; v.ready = 1'b1;
        run_cycle(v, ex(1, 1, 0, 0, 0, 0, 0, 2'd1), "mstall_ready");
        run_cycle(idle, E_RUN, "mstall_after");

        // mult issue, mfhi reaches ID two cycles later
        run_cycle(mds_v, E_RUN, "md_issue");
        run_cycle(idle, MD_EN ? ex(1, 1, 0, 0, 0, 1, 0, 2'd2) : E_RUN, "md_n0");
        for (int k = 1; k <= 3; k++)
            run_cycle(hilo, MD_EN ? ex(0, 0, 0, 1, 0, 1, 0, 2'd2) : E_RUN, $sformatf("md_hilo_stall%0d", k));
        run_cycle(hilo, E_RUN, "md_mfhi_proceeds");

        // Reset during MULDIV
        run_cycle(mds_v, E_RUN, "md_rst_issue");
        run_cycle(rst_v, E_RUN, "md_rst_assert");
        run_cycle(hilo, E_RUN, "md_rst_after");

        // Memory stall while the mult/div counter runs
        run_cycle(mds_v, E_RUN, "mdm_issue");
        run_cycle(stall, ex(0, 0, 0, 0, 1, MD_EN, 0, MD_EN ? 2'd2 : 2'd0), "mdm_stall1");
        run_cycle(stall, ex(0, 0, 0, 0, 1, MD_EN, 0, 2'd1), "mdm_stall2");
        v = stall; v.ready = 1'b1;
        run_cycle(v, ex(1, 1, 0, 0, 0, MD_EN, 0, 2'd1), "mdm_ready");
        run_cycle(idle, MD_EN ? ex(1, 1, 0, 0, 0, 1, 0, 2'd2) : E_RUN, "mdm_last_busy");
        run_cycle(idle, E_RUN, "mdm_done");

        // Memory timeout: sticky past ready, cleared only by reset
        for (int k = 1; k <= 10; k++)
            run_cycle(stall, ex(0, 0, 0, 0, 1, 0, (k >= 9), (k == 1) ? 2'd0 : 2'd1),
                      $sformatf("tmo_stall%0d", k));
        v = stall; v.ready = 1'b1;
        run_cycle(v, ex(1, 1, 0, 0, 0, 0, 1, 2'd1), "tmo_ready");
        run_cycle(idle, ex(1, 1, 0, 0, 0, 0, 1, 2'd0), "tmo_sticky");
        run_cycle(rst_v, E_RUN, "tmo_reset");
        run_cycle(idle, E_RUN, "tmo_cleared");

        // Reset asserted mid-stall aborts the freeze
        run_cycle(stall, ex(0, 0, 0, 0, 1, 0, 0, 2'd0), "rstall_c1");
        v = stall; v.rst = 1'b1;
        run_cycle(v, E_RUN, "rstall_reset");
        run_cycle(idle, E_RUN, "rstall_after");

        checks++;
        if (sb_exp.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_exp.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
